// File: rtl/csr_exec_if.sv
//------------------------------------------------------------------------------
// csr_exec_if : issue, csr-block and writeback signals of the CSR sequencer
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface csr_exec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [11:0]     in_addr;
    logic [4:0]      in_src;
    logic [XLEN-1:0] in_rs1_data;
    logic [4:0]      in_rd;
    logic [11:0]     csr_addr;
    logic            csr_wen;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_data;
    logic            out_illegal;
    logic            is_done_inst;

    modport slave (
        input  in_valid, in_funct3, in_addr, in_src, in_rs1_data, in_rd,
        input  csr_rdata, out_ready,
        output in_ready, csr_addr, csr_wen, csr_wdata,
        output out_valid, out_rd, out_data, out_illegal, is_done_inst
    );

    modport master (
        output in_valid, in_funct3, in_addr, in_src, in_rs1_data, in_rd,
        output csr_rdata, out_ready,
        input  in_ready, csr_addr, csr_wen, csr_wdata,
        input  out_valid, out_rd, out_data, out_illegal, is_done_inst
    );
endinterface

`default_nettype wire

// File: rtl/csr_exec.sv
//------------------------------------------------------------------------------
// csr_exec : execute-stage sequencer for Zicsr instructions (IDLE/READ/WRITE/RESP)
// Option   : CSR_EXEC_ROCHECK_EN flags writes to addr[11:10]==2'b11 as illegal
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module csr_exec #(
    parameter int XLEN = 32
) (
    input  wire logic clock,
    input  wire logic reset,
    csr_exec_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [2:0]      funct3_q;
    logic [4:0]      src_q;
    logic [XLEN-1:0] rs1_q;
    logic [11:0]     csr_addr_q;
    logic            csr_wen_q;
    logic [XLEN-1:0] wdata_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [4:0]      out_rd_q;
    logic [XLEN-1:0] out_data_q;
    logic            illegal_q;

    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] wdata_d;
    logic            do_write;
    logic            ro_fault;
    logic            in_legal;

    always_comb begin
        operand  = funct3_q[2] ? {{(XLEN-5){1'b0}}, src_q} : rs1_q;
        do_write = (funct3_q[1:0] == 2'b01) || (src_q != 5'd0);
        in_legal = (bus.in_funct3[1:0] != 2'b00);
        case (funct3_q[1:0])
            2'b10:   wdata_d = bus.csr_rdata | operand;
            2'b11:   wdata_d = bus.csr_rdata & ~operand;
            default: wdata_d = operand;
        endcase
`ifdef CSR_EXEC_ROCHECK_EN
        ro_fault = do_write && (csr_addr_q[11:10] == 2'b11);
`else
        ro_fault = 1'b0;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            funct3_q    <= 3'd0;
            src_q       <= 5'd0;
            rs1_q       <= '0;
            csr_addr_q  <= 12'd0;
            csr_wen_q   <= 1'b0;
            wdata_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_rd_q    <= 5'd0;
            out_data_q  <= '0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        funct3_q   <= bus.in_funct3;
                        src_q      <= bus.in_src;
                        rs1_q      <= bus.in_rs1_data;
                        out_rd_q   <= bus.in_rd;
                        if (in_legal) begin
                            illegal_q  <= 1'b0;
                            csr_addr_q <= bus.in_addr;
                            state_q    <= S_READ;
                        end else begin
                            // Reserved funct3: answer immediately, never touch the csr block
                            illegal_q   <= 1'b1;
                            out_data_q  <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end
                    end
                end
                S_READ: begin
                    if (ro_fault) begin
                        illegal_q   <= 1'b1;
                        out_data_q  <= '0;
                        csr_addr_q  <= 12'd0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        out_data_q <= bus.csr_rdata;
                        wdata_q    <= wdata_d;
                        if (do_write) begin
                            csr_wen_q <= 1'b1;
                            state_q   <= S_WRITE;
                        end else begin
                            csr_addr_q  <= 12'd0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end
                    end
                end
                S_WRITE: begin
                    csr_wen_q   <= 1'b0;
                    csr_addr_q  <= 12'd0;
                    out_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                default: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.csr_addr     = csr_addr_q;
    assign bus.csr_wen      = csr_wen_q;
    assign bus.csr_wdata    = wdata_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_rd       = out_rd_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_illegal  = illegal_q;
    // Retire coincides with the writeback handshake
    assign bus.is_done_inst = out_valid_q & bus.out_ready & ~illegal_q;

endmodule

`default_nettype wire

// File: doc/csr_exec.md
Name: csr_exec

Overview:
- Execute-stage sequencer for Zicsr instructions: CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI and CSRRCI.
- Sits between the decode/issue stage and the csr register block. Drives the block's addr, wen and wdata, samples its rdata, and returns the old CSR value for rd writeback.
- Generates the is_done_inst retire pulse that feeds the csr block's minstret counter.
- Processes one instruction at a time, with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, data width; matches the csr block word width.

Ports:
- clock  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- in_valid  input  1  issue stage presents a CSR instruction.
- in_ready  output  1  block can accept an instruction.
- in_funct3  input  3  instruction funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- in_addr  input  12  CSR address, inst[31:20].
- in_src  input  5  rs1 index, or the 5-bit uimm for the I-forms.
- in_rs1_data  input  XLEN  rs1 register value.
- in_rd  input  5  destination register index.
- csr_addr  output  12  address to the csr block.
- csr_wen  output  1  CSR write strobe.
- csr_wdata  output  XLEN  CSR write data.
- csr_rdata  input  XLEN  combinational read data from the csr block.
- out_valid  output  1  result available.
- out_ready  input  1  writeback stage accepts the result.
- out_rd  output  5  latched rd.
- out_data  output  XLEN  old CSR value.
- out_illegal  output  1  instruction was illegal.
- is_done_inst  output  1  one-cycle retire pulse to the csr block.

Behaviour:
- Reset values:
  - All outputs 0, except in_ready=1.
  - State IDLE.
  - All internal latches 0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch funct3, addr, src, rs1_data and rd, then go to READ.
  - Illegal funct3 (000 or 100): latch instead, set illegal=1, data=0, go to RESP. No CSR access occurs.
  - READ: csr_addr=latched addr. Capture csr_rdata into old and compute new:
    - RW: new = rs1_data.
    - RS: new = old | rs1_data.
    - RC: new = old & ~rs1_data.
    - I-forms: use the zero-extended uimm in place of rs1_data.
  - Write decision: write for RW/RWI always; for S/C forms only if src!=0. Go to WRITE if writing, else RESP.
  - WRITE: csr_wen=1 for exactly this cycle, csr_addr=latched addr, csr_wdata=new. Then go to RESP.
  - RESP: out_valid=1; out_rd, out_data=old and out_illegal are held stable while out_valid&&!out_ready.
    - On out_valid&&out_ready, go to IDLE.
    - On the same handshake, is_done_inst=1 for one cycle, but only if !illegal.
- Latency:
  - Input handshake in cycle N, READ in N+1, WRITE in N+2.
  - out_valid from N+3 with a write, N+2 without.
  - Next instruction is accepted no earlier than the cycle after the output handshake; no overlap.
- Timing and boundaries:
  - csr_addr is 0 in IDLE and RESP. csr_wen is 0 outside WRITE.
  - out_data reflects the counter value sampled in READ. A counter written in WRITE shows the written value on the next cycle, and the write overrides that cycle's increment.
  - rd=0 still performs the read and the write; out_rd=0 is passed on unchanged.
  - Reset asserted in any state: immediately IDLE, csr_wen=0, out_valid=0 and is_done_inst=0. No partial write completes.
  - Width: uimm zero-extended to XLEN; all logic operations are XLEN bits wide, with no sign extension.

Optional Feature:
- Macro CSR_EXEC_ROCHECK_EN.
- Defined: a write decision to an address with addr[11:10]==2'b11 (read-only space, e.g. 12'hF11) sets illegal=1, skips WRITE, goes to RESP with out_data=0, and gives no is_done_inst.
  - An S/C form with src=0 to read-only space remains legal.
- Undefined: no read-only check; the write strobe is issued and the csr block ignores unwritable addresses.

Test Plan:
1. After reset, CSRRW addr 12'hB00 with rs1_data=32'h100 → csr_wen pulses once with wdata 32'h100. out_data equals the mcycle low word sampled in READ. A following CSRRS 12'hB00, src=0 returns 32'h100 + cycles elapsed.
2. CSRRS addr 12'hF11, src=0 → no csr_wen; out_data=32'h6265_6B61; out_valid arrives 2 cycles after the input handshake; is_done_inst pulses once.
3. CSRRWI 12'hB02 uimm=5'h1F, then CSRRCI 12'hB02 uimm=5'h03 → second instruction writes wdata=32'h1C (if no intervening retire increment) and out_data equals the minstret value read.
4. Hold out_ready=0 for 5 cycles in RESP → out_valid, out_rd and out_data stable; in_ready=0; exactly one is_done_inst pulse when out_ready rises.
5. funct3=3'b100 → out_illegal=1, out_data=0, no csr_wen, no is_done_inst. With CSR_EXEC_ROCHECK_EN, CSRRW to 12'hF12 behaves the same.
6. Assert reset during WRITE → csr_wen drops in the same cycle, out_valid=0, in_ready=1 after reset is released.
